// File: rtl/mul_seq.sv
// mul_seq -- multi-cycle RV32M multiply sequencer.
//
// Builds the full 2*XLEN-bit product over four CALC cycles from one
// XLEN/2 x XLEN/2 unsigned multiplier. Signed operands are handled by
// multiplying magnitudes and negating the 64-bit product in FIX.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   in_valid   request present
//   in_ready   sequencer idle and able to accept
//   op         00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   a, b       rs1 / rs2 operands (sampled only at accept)
//   flush      abort in-flight op / block accept in IDLE
//   out_valid  result valid (DONE)
//   out_ready  consumer accepts result
//   result     selected product word, held stable while out_valid
module mul_seq #(
  parameter int XLEN       = 32,
  parameter bit EARLY_ZERO = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam int H = XLEN / 2;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  // Operation context captured at accept.
  typedef struct packed {
    logic [1:0]      op;
    logic            neg;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
  } req_t;

  state_t            state, state_nxt;
  req_t              req_q, req_d;
  logic [2*XLEN-1:0] acc;
  logic [1:0]        cnt;
  logic [XLEN-1:0]   result_q;

  logic              sgn_a, sgn_b, accept, zero_in;
  logic [H-1:0]      half_a, half_b;
  logic [XLEN-1:0]   pp;
  logic [2*XLEN-1:0] pp_ext, pp_sh, prod;
  logic [XLEN-1:0]   fix_word;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = result_q;

  // Sign decode; MUL treats both as unsigned since the low word is unaffected.
  assign sgn_a   = ((op == 2'b01) || (op == 2'b10)) && a[XLEN-1];
  assign sgn_b   = (op == 2'b01) && b[XLEN-1];
  assign accept  = in_valid && in_ready && !flush;
  assign zero_in = EARLY_ZERO && ((a == '0) || (b == '0));

  always_comb begin
    req_d.op    = op;
    req_d.neg   = sgn_a ^ sgn_b;
    // Negating 0x80000000 yields 0x80000000, which is the correct unsigned magnitude.
    req_d.mag_a = sgn_a ? (~a + 1'b1) : a;
    req_d.mag_b = sgn_b ? (~b + 1'b1) : b;
  end

  // cnt[1] picks the high half of a, cnt[0] the high half of b:
  // 0 lo*lo, 1 lo*hi, 2 hi*lo, 3 hi*hi.
  assign half_a = cnt[1] ? req_q.mag_a[XLEN-1:H] : req_q.mag_a[H-1:0];
  assign half_b = cnt[0] ? req_q.mag_b[XLEN-1:H] : req_q.mag_b[H-1:0];
  assign pp     = half_a * half_b;
  assign pp_ext = {{XLEN{1'b0}}, pp};

  always_comb begin
    pp_sh = pp_ext;
    case (cnt)
      2'd0:    pp_sh = pp_ext;
      2'd3:    pp_sh = pp_ext << XLEN;
      default: pp_sh = pp_ext << H;
    endcase
  end

  assign prod     = req_q.neg ? (~acc + 1'b1) : acc;
  assign fix_word = (req_q.op == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = zero_in ? DONE : CALC;
      CALC: begin
        if (flush)           state_nxt = IDLE;
        else if (cnt == 2'd3) state_nxt = FIX;
      end
      FIX:  state_nxt = flush ? IDLE : DONE;
      DONE: if (flush || out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      req_q    <= '0;
      acc      <= '0;
      cnt      <= '0;
      result_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        req_q <= req_d;
        acc   <= '0;
        cnt   <= '0;
        if (zero_in) result_q <= '0;
      end
      if (state == CALC && !flush) begin
        acc <= acc + pp_sh;
        cnt <= cnt + 2'd1;
      end
      if (state == FIX && !flush) result_q <= fix_word;
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
module tb_mul_seq;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_valid0 = 1'b0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b1, out_ready0 = 1'b1;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0;
  logic        in_ready, out_valid, in_ready0, out_valid0;
  logic [31:0] result, result0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mul_seq #(.XLEN(32), .EARLY_ZERO(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .result(result));

  mul_seq #(.XLEN(32), .EARLY_ZERO(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .op(op), .a(a), .b(b), .flush(flush), .out_valid(out_valid0),
    .out_ready(out_ready0), .result(result0));

  // Reference: exact 64-bit product of the sign/zero-extended operands.
  function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy;
    logic [63:0] p;
    sx = (o == 2'b01 || o == 2'b10) ? longint'($signed(x)) : longint'({32'b0, x});
    sy = (o == 2'b01) ? longint'($signed(y)) : longint'({32'b0, y});
    p  = 64'(sx * sy);
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Stimulus helper (no checking): issue one request with out_ready high,
  // report result, edges from accept to out_valid, and out_valid after consume.
  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input bit alt,
                       output logic [31:0] res, output int lat, output bit ov_after);
    op = o; a = x; b = y;
    if (alt) in_valid0 = 1'b1; else in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_valid0 = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom);
    lat = 0;
    while (!(alt ? out_valid0 : out_valid) && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    res = alt ? result0 : result;
    @(posedge clk); #1;
    ov_after = alt ? out_valid0 : out_valid;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (result !== 32'h0)   begin errors++; $display("FAIL reset_result got=%h exp=0", result); end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed;
    logic [1:0]  to[9] = '{2'b00, 2'b11, 2'b00, 2'b01, 2'b10, 2'b11, 2'b01, 2'b10, 2'b00};
    logic [31:0] ta[9] = '{32'h12345678, 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                           32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'h80000000};
    logic [31:0] tb[9] = '{32'h87654321, 32'h87654321, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                           32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h80000000};
    logic [31:0] te[9] = '{32'h70B88D78, 32'h09A0CD05, 32'h00000001, 32'h00000000, 32'hFFFFFFFF,
                           32'hFFFFFFFE, 32'h40000000, 32'h80000000, 32'h00000000};
    logic [31:0] r; int lat; bit ova;
    for (int i = 0; i < 9; i++) begin
      issue(to[i], ta[i], tb[i], 1'b0, r, lat, ova);
      checks++; if (r !== te[i]) begin errors++; $display("FAIL directed_result[%0d] got=%h exp=%h", i, r, te[i]); end
      checks++; if (lat != 5)    begin errors++; $display("FAIL directed_latency[%0d] got=%0d exp=5", i, lat); end
      checks++; if (ova !== 1'b0) begin errors++; $display("FAIL directed_hold[%0d] out_valid after consume got=%b exp=0", i, ova); end
    end
  endtask

  task automatic test_early_zero;
    logic [31:0] r; int lat; bit ova;
    // Shortcut: out_valid right after the accept edge.
    issue(2'b01, 32'h0, 32'hFFFFFFFF, 1'b0, r, lat, ova);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL ez_result got=%h exp=0", r); end
    checks++; if (lat != 0)    begin errors++; $display("FAIL ez_latency got=%0d exp=0", lat); end
    issue(2'b11, 32'h1234ABCD, 32'h0, 1'b0, r, lat, ova);
    checks++; if (r !== 32'h0 || lat != 0) begin errors++; $display("FAIL ez_b_zero got=%h lat=%0d exp=0 lat=0", r, lat); end
    // Same stimulus with the shortcut disabled runs the full sequence.
    issue(2'b01, 32'h0, 32'hFFFFFFFF, 1'b1, r, lat, ova);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL noez_result got=%h exp=0", r); end
    checks++; if (lat != 5)    begin errors++; $display("FAIL noez_latency got=%0d exp=5", lat); end
  endtask

  task automatic test_random;
    logic [1:0] o; logic [31:0] x, y, e, r; int lat, elat; bit ova;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom);
      case ($urandom_range(0, 7))
        0: x = 32'h0; 1: x = 32'h80000000; 2: x = 32'hFFFFFFFF; default: x = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: y = 32'h0; 1: y = 32'h80000000; 2: y = 32'hFFFFFFFF; default: y = $urandom;
      endcase
      e    = ref_mul(o, x, y);
      elat = (x == 0 || y == 0) ? 0 : 5;
      issue(o, x, y, (i % 4) == 3, r, lat, ova);
      if ((i % 4) == 3) elat = 5;
      checks++; if (r !== e || lat != elat) begin
        errors++; $display("FAIL random[%0d] op=%0d a=%h b=%h got=%h lat=%0d exp=%h lat=%0d", i, o, x, y, r, lat, e, elat);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] e1, e2, r; int lat; bit stable;
    e1 = ref_mul(2'b01, 32'hDEADBEEF, 32'h0BADF00D);
    e2 = ref_mul(2'b10, 32'hF0000001, 32'h7FFFFFFF);
    out_ready = 1'b0;
    op = 2'b01; a = 32'hDEADBEEF; b = 32'h0BADF00D; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    checks++; if (lat != 5) begin errors++; $display("FAIL bp_latency got=%0d exp=5", lat); end
    op = 2'b10; a = 32'hF0000001; b = 32'h7FFFFFFF; in_valid = 1'b1;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || result !== e1 || in_ready !== 1'b0) stable = 1'b0;
      @(posedge clk); #1;
    end
    checks++; if (!stable || result !== e1) begin errors++; $display("FAIL bp_hold got=%h ov=%b ir=%b exp=%h ov=1 ir=0", result, out_valid, in_ready, e1); end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready); end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_next_accept in_ready got=%b exp=0", in_ready); end
    in_valid = 1'b0; a = $urandom; b = $urandom;
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    r = result;
    checks++; if (r !== e2 || lat != 5) begin errors++; $display("FAIL bp_second got=%h lat=%0d exp=%h lat=5", r, lat, e2); end
    @(posedge clk); #1;
  endtask

  task automatic test_flush;
    bit seen;
    // Flush during the second CALC cycle.
    op = 2'b11; a = 32'h11111111; b = 32'h22222222; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL flush_calc ir=%b ov=%b exp ir=1 ov=0", in_ready, out_valid); end
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    checks++; if (seen) begin errors++; $display("FAIL flush_no_result out_valid pulse got=1 exp=0"); end
    // Flush in IDLE blocks acceptance.
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0; flush = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_idle in_ready got=%b exp=1", in_ready); end
    // Flush wins over out_ready in DONE.
    op = 2'b00; a = 32'h5; b = 32'h0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_done_setup out_valid got=%b exp=1", out_valid); end
    out_ready = 1'b0; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0; out_ready = 1'b1;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_done ov=%b ir=%b exp ov=0 ir=1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] r; int lat; bit ova;
    op = 2'b01; a = 32'h89ABCDEF; b = 32'h76543210; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (4) @(posedge clk);   // four CALC edges; now in FIX
    #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    checks++; if (out_valid !== 1'b0 || result !== 32'h0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_fix ov=%b res=%h ir=%b exp ov=0 res=0 ir=1", out_valid, result, in_ready);
    end
    issue(2'b00, 32'd7, 32'd6, 1'b0, r, lat, ova);
    checks++; if (r !== 32'h0000002A || lat != 5) begin errors++; $display("FAIL after_reset got=%h lat=%0d exp=0000002a lat=5", r, lat); end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_early_zero;
    test_random;
    test_back_to_back;
    test_flush;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
